// File: rtl/dds_pkg.sv
// Shared constants and types for the per-channel DDS engine.
// Edit the constants here to resize every channel consistently.
package dds_pkg;

    localparam int VERTICAL_RESOLUTION = 8;
    localparam int HORIZON_RESOLUTION  = 12;
    localparam int ADDER_LOWBIT        = 20;
    localparam int WAVE_STORE          = 2;
    localparam int ACC_W               = HORIZON_RESOLUTION + ADDER_LOWBIT;
    localparam int NUM_TABLES          = 1 << WAVE_STORE;

    typedef logic [ACC_W-1:0]               acc_t;
    typedef logic [HORIZON_RESOLUTION-1:0]  haddr_t;
    typedef logic [VERTICAL_RESOLUTION-1:0] sample_t;

    localparam sample_t MIDSCALE = sample_t'(1 << (VERTICAL_RESOLUTION - 1));

endpackage

// File: rtl/dds_wave_ram.sv
// Simple dual-port waveform store: one synchronous write port, one registered read port.
// No reset so the array maps onto block RAM.
module dds_wave_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dds_channel_core.sv
// One DDS output channel: phase accumulator, phase offset, table lookup and a
// table-load path that streams samples into the selected waveform table.
module dds_channel_core
    import dds_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     DDS_SLAVE_RSTN_SYNC,
    input  logic [WAVE_STORE-1:0]                    wave_sel,
    input  logic [NUM_TABLES*ACC_W-1:0]              freq_ctrl,
    input  logic [NUM_TABLES*HORIZON_RESOLUTION-1:0] phase_ctrl,
    input  logic                                     wr_enable,
    input  logic                                     wr_valid,
    input  logic [31:0]                              wr_data,
    output logic [VERTICAL_RESOLUTION-1:0]           wave_out
);

    localparam int RAM_AW = WAVE_STORE + HORIZON_RESOLUTION;

    acc_t   freq_word  [NUM_TABLES];
    haddr_t phase_word [NUM_TABLES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TABLES; gi++) begin : g_unpack
            assign freq_word[gi]  = freq_ctrl[gi*ACC_W +: ACC_W];
            assign phase_word[gi] = phase_ctrl[gi*HORIZON_RESOLUTION +: HORIZON_RESOLUTION];
        end
    endgenerate

    acc_t                  acc_reg;
    haddr_t                addr_reg;
    logic [WAVE_STORE-1:0] sel_reg;
    haddr_t                wr_ptr_reg;
    logic                  load_d1_reg;
    logic                  load_d2_reg;
    logic                  live_d1_reg;
    logic                  live_d2_reg;
    sample_t               wave_out_reg;
    sample_t               ram_q;

    logic                  load_start;
    haddr_t                wr_base;
    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_waddr;
    logic [RAM_AW-1:0]     ram_raddr;
    logic                  unused_wr_bits;

    // The first cycle of a load writes at address 0 regardless of the stale pointer.
    assign load_start     = wr_enable & ~load_d1_reg;
    assign wr_base        = load_start ? '0 : wr_ptr_reg;
    assign ram_we         = wr_enable & wr_valid;
    assign ram_waddr      = {wave_sel, wr_base};
    assign ram_raddr      = {sel_reg, addr_reg};
    assign unused_wr_bits = ^wr_data[31:VERTICAL_RESOLUTION];

    dds_wave_ram #(
        .DATA_W (VERTICAL_RESOLUTION),
        .ADDR_W (RAM_AW)
    ) u_wave_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (wr_data[VERTICAL_RESOLUTION-1:0]),
        .rd_addr (ram_raddr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
        if (!DDS_SLAVE_RSTN_SYNC) begin
            acc_reg      <= '0;
            addr_reg     <= '0;
            sel_reg      <= '0;
            wr_ptr_reg   <= '0;
            load_d1_reg  <= 1'b0;
            load_d2_reg  <= 1'b0;
            live_d1_reg  <= 1'b0;
            live_d2_reg  <= 1'b0;
            wave_out_reg <= '0;
        end else begin
            acc_reg  <= wr_enable ? '0 : acc_reg + freq_word[wave_sel];
            addr_reg <= acc_reg[ACC_W-1 -: HORIZON_RESOLUTION] + phase_word[wave_sel];
            sel_reg  <= wave_sel;

            if (wr_enable) begin
                wr_ptr_reg <= wr_base + haddr_t'(wr_valid);
            end

            load_d1_reg <= wr_enable;
            load_d2_reg <= load_d1_reg;
            // Holds the output at zero until the first post-reset read has reached ram_q.
            live_d1_reg <= 1'b1;
            live_d2_reg <= live_d1_reg;

            // Mid-scale covers the load window plus the pipeline refill after it.
            if (wr_enable | load_d1_reg | load_d2_reg) begin
                wave_out_reg <= MIDSCALE;
            end else if (!live_d2_reg) begin
                wave_out_reg <= '0;
            end else begin
                wave_out_reg <= ram_q;
            end
        end
    end

    assign wave_out = wave_out_reg;

endmodule

// File: tb/tb_dds_channel_core.sv
// Self-checking bench for dds_channel_core: directed scenarios plus a randomized
// run against a sample-level reference model.
module tb_dds_channel_core;
    import dds_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   wave_sel = '0;
    logic [127:0] freq_ctrl = '0;
    logic [47:0]  phase_ctrl = '0;
    logic         wr_enable = 1'b0;
    logic         wr_valid = 1'b0;
    logic [31:0]  wr_data = '0;
    logic [7:0]   wave_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dds_channel_core dut (
        .clk                 (clk),
        .DDS_SLAVE_RSTN_SYNC (rst_n),
        .wave_sel            (wave_sel),
        .freq_ctrl           (freq_ctrl),
        .phase_ctrl          (phase_ctrl),
        .wr_enable           (wr_enable),
        .wr_valid            (wr_valid),
        .wr_data             (wr_data),
        .wave_out            (wave_out)
    );

    // Reference: table contents, phase accumulator, load pointer, and the samples
    // looked up on the last two edges (a lookup shows on wave_out two edges later).
    logic [7:0]  m_mem [4][4096];
    logic [31:0] m_acc;
    logic [11:0] m_ptr;
    logic        m_prev_en;
    logic [7:0]  look1, look2;
    logic        en1, en2;

    task automatic model_reset();
        m_acc = '0; m_ptr = '0; m_prev_en = 1'b0;
        look1 = '0; look2 = '0; en1 = 1'b0; en2 = 1'b0;
    endtask

    task automatic set_freq(input int k, input logic [31:0] v);
        freq_ctrl[k*32 +: 32] = v;
    endtask

    task automatic set_phase(input int k, input logic [11:0] v);
        phase_ctrl[k*12 +: 12] = v;
    endtask

    // Advance one clock; returns what wave_out must show after this edge.
    task automatic tick(output logic [7:0] exp_v);
        int s;
        logic [11:0] a;
        s = int'(wave_sel);
        a = m_acc[31:20] + phase_ctrl[s*12 +: 12];
        exp_v = (wr_enable || en1 || en2) ? 8'h80 : look2;
        look2 = look1;
        look1 = m_mem[s][a];
        en2 = en1;
        en1 = wr_enable;
        if (wr_enable) begin
            if (!m_prev_en) m_ptr = '0;
            if (wr_valid) begin
                m_mem[s][m_ptr] = wr_data[7:0];
                m_ptr = m_ptr + 12'd1;
            end
            m_acc = '0;
        end else begin
            m_acc = m_acc + freq_ctrl[s*32 +: 32];
        end
        m_prev_en = wr_enable;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ramp, 1: constant cval, 2: random
    task automatic load_table(input int sel, input int mode, input logic [7:0] cval);
        logic [7:0] e;
        wave_sel  = 2'(sel);
        wr_enable = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            wr_valid = 1'b1;
            wr_data  = (mode == 0) ? 32'(i & 255) : (mode == 1) ? {24'd0, cval} : $urandom;
            tick(e);
        end
        wr_valid  = 1'b0;
        wr_enable = 1'b0;
        wr_data   = '0;
    endtask

    // One load-mode cycle without writes clears acc; leaves the two refill ticks done.
    task automatic restart();
        logic [7:0] e;
        wr_enable = 1'b1;
        tick(e);
        wr_enable = 1'b0;
        tick(e);
        tick(e);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (wave_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d wave_out=%02h expected=00", i, wave_out);
            end
        end
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick(e);
            n_checks++;
            if (wave_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d wave_out=%02h expected=00", i, wave_out);
            end
        end
    endtask

    task automatic test_ramp_wrap();
        logic [7:0] e, ev;
        load_table(0, 0, 8'h00);
        n_checks++;
        if (wave_out !== 8'h80) begin
            n_fail++;
            $display("FAIL load_midscale wave_out=%02h expected=80", wave_out);
        end
        set_freq(0, 32'h0010_0000);
        set_phase(0, 12'h000);
        for (int t = 0; t < 4096 + 2 + 40; t++) begin
            tick(e);
            ev = (t < 2) ? 8'h80 : 8'(t - 2);
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL ramp_wrap t=%0d wave_out=%02h expected=%02h", t, wave_out, ev);
            end
        end
    endtask

    task automatic test_fraction();
        logic [7:0] e, ev;
        set_freq(0, 32'h0008_0000);
        set_phase(0, 12'h005);
        restart();
        for (int t = 0; t < 60; t++) begin
            tick(e);
            ev = 8'(5 + t / 2);
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL fraction t=%0d wave_out=%02h expected=%02h", t, wave_out, ev);
            end
        end
    endtask

    task automatic test_table_switch();
        logic [7:0] e, ev;
        int sel_hist [40];
        load_table(1, 1, 8'hAA);
        wave_sel = 2'd0;
        set_freq(0, 32'h0010_0000); set_freq(1, 32'h0010_0000);
        set_phase(0, 12'h000);      set_phase(1, 12'h000);
        restart();
        for (int t = 0; t < 40; t++) begin
            if (t == 10) wave_sel = 2'd1;
            if (t == 17) wave_sel = 2'd0;
            sel_hist[t] = int'(wave_sel);
            tick(e);
            ev = (t >= 2 && sel_hist[t-2] == 1) ? 8'hAA : 8'(t);
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL table_switch t=%0d wave_out=%02h expected=%02h", t, wave_out, ev);
            end
        end
    endtask

    task automatic test_ignored_strobe();
        logic [7:0] e, ev;
        wave_sel = 2'd0;
        restart();
        for (int t = 0; t < 20; t++) begin
            wr_valid = (t >= 5 && t < 10);
            wr_data  = 32'h0000_0033;
            tick(e);
            ev = 8'(t);
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL strobe_run t=%0d wave_out=%02h expected=%02h", t, wave_out, ev);
            end
        end
        wr_valid = 1'b0;
        restart();
        for (int t = 0; t < 300; t++) begin
            tick(e);
            ev = 8'(t);
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL strobe_ramp t=%0d wave_out=%02h expected=%02h", t, wave_out, ev);
            end
        end
    endtask

    task automatic test_pointer_restart();
        logic [7:0] e, ev;
        logic [7:0] orig [20];
        logic [7:0] beat [10];
        load_table(2, 2, 8'h00);
        for (int i = 0; i < 20; i++) orig[i] = m_mem[2][i];
        wave_sel  = 2'd2;
        wr_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = $urandom;
            beat[i]  = wr_data[7:0];
            tick(e);
        end
        wr_valid = 1'b0; wr_enable = 1'b0;
        tick(e); tick(e);
        wr_enable = 1'b1;
        tick(e);
        wr_valid = 1'b1; wr_data = 32'h0000_0077;
        tick(e);
        wr_valid = 1'b0; wr_enable = 1'b0;
        set_freq(2, 32'h0010_0000);
        set_phase(2, 12'h000);
        restart();
        for (int t = 0; t < 20; t++) begin
            tick(e);
            ev = (t == 0) ? 8'h77 : (t < 10) ? beat[t] : orig[t];
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL ptr_restart addr=%0d wave_out=%02h expected=%02h", t, wave_out, ev);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        load_table(3, 2, 8'h00);
        for (int k = 0; k < 4; k++) begin
            set_freq(k, $urandom);
            set_phase(k, 12'($urandom));
        end
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(15) == 0) wave_sel = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) set_freq(int'($urandom_range(3)), $urandom);
            if ($urandom_range(31) == 0) set_phase(int'($urandom_range(3)), 12'($urandom));
            wr_enable = ($urandom_range(199) == 0);
            wr_valid  = !wr_enable && ($urandom_range(7) == 0);
            wr_data   = $urandom;
            tick(e);
            n_checks++;
            if (wave_out !== e) begin
                n_fail++;
                $display("FAIL random t=%0d wave_out=%02h expected=%02h", t, wave_out, e);
            end
        end
        wr_enable = 1'b0;
        wr_valid  = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [7:0] e, ev;
        wave_sel = 2'd0;
        set_freq(0, 32'h0010_0000);
        set_phase(0, 12'h000);
        restart();
        for (int t = 0; t < 30; t++) begin
            tick(e);
            ev = 8'(t);
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL pre_reset t=%0d wave_out=%02h expected=%02h", t, wave_out, ev);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (wave_out !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset wave_out=%02h expected=00", wave_out);
        end
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            tick(e);
            ev = (k < 2) ? 8'h00 : 8'(k - 2);
            n_checks++;
            if (wave_out !== ev) begin
                n_fail++;
                $display("FAIL post_reset k=%0d wave_out=%02h expected=%02h", k, wave_out, ev);
            end
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        test_reset();
        test_ramp_wrap();
        test_fraction();
        test_table_switch();
        test_ignored_strobe();
        test_pointer_restart();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
